pll_lock_detect: RTL and testbench
==================================

// Module: pll_lock_detect
// PURPOSE
//  Lock/frequency monitor for the ring-oscillator PLL, clocked on the PLL output pclk.
//  - Counts pclk cycles between rising edges of refclk, which it receives as async data.
//  - Compares each count to the programmed divider N and drives locked/fast/slow status.
//  - Sits beside the pll instance; it is the consumer of the pclk = N*refclk relation the PLL produces.
// PARAMETERS
//  NW          8   width of n_div; count width CW = NW+2
//  TOL         1   allowed |count - N| for a window to be "good"
//  LOCK_CNT    4   consecutive good windows required to assert locked
//  UNLOCK_CNT  2   consecutive bad windows required to deassert locked
// PORTS
//  pclk        in   1      sole clock (PLL output)
//  reset       in   1      synchronous, active-high
//  en          in   1      monitor enable
//  refclk_in   in   1      reference clock, asynchronous to pclk, treated as data
//  n_div       in   NW     expected pclk cycles per refclk period
//  meas_valid  out  1      one-cycle pulse: new window result available
//  meas_count  out  CW     pclk cycles in the last complete refclk window
//  fast        out  1      last window count > N+TOL
//  slow        out  1      last window count < N-TOL
//  locked      out  1      lock indication
//  timeout     out  1      no refclk edge within 2^CW-1 cycles (sticky until next edge)
// BEHAVIOUR
//  Reset: all outputs 0, cnt=0, sync flops 0, state IDLE.
//  Synchronizer and edge detection:
//   - refclk_in -> s1 -> s2 (2FF) -> s3.
//   - edge = s2 & ~s3.
//   - Outputs are registered on the edge cycle, so meas_valid is high 3 pclk edges after refclk_in is first sampled high.
//  Counter:
//   - On edge: meas_count<=cnt, cnt<=1.
//   - Otherwise cnt<=cnt+1, saturating at 2^CW-1.
//   - A refclk period of exactly 32 pclk gives meas_count=32.
//  Window FSM:
//   - IDLE: en=0. locked, fast and slow are held 0.
//   - IDLE->ACQ when en=1.
//   - ACQ: the first edge only restarts cnt. No meas_valid (the partial window is discarded). ACQ->MEAS.
//   - MEAS: every edge produces meas_valid plus classification.
//   - en=0 in any state -> IDLE next cycle; locked=0 that cycle.
//  Classification, computed in CW+1-bit unsigned arithmetic, no overflow:
//   - good when n_div-TOL <= count <= n_div+TOL, with the lower bound clamped at 0.
//   - fast and slow are mutually exclusive; both are 0 when good.
//   - Updated only with meas_valid.
//  Lock FSM (sub-state of MEAS):
//   - UNLOCKED: good_cnt counts consecutive good windows. A bad window clears it.
//   - good_cnt==LOCK_CNT -> LOCKED. locked=1 in the same cycle as that meas_valid.
//   - LOCKED: bad_cnt counts consecutive bad windows. A good window clears it.
//   - bad_cnt==UNLOCK_CNT -> UNLOCKED. locked=0 with that meas_valid.
//  n_div handling:
//   - n_div is latched into n_lat on entry to ACQ.
//   - Any n_div != n_lat while in MEAS: locked=0, counters cleared, FSM -> ACQ next cycle.
//   - n_lat < 2: windows are still reported but always classed bad; locked never asserts.
//  Timeout:
//   - cnt reaching 2^CW-1 sets timeout=1 and locked=0, and sends the FSM to ACQ.
//   - timeout clears on the next edge.
//  Reset mid-operation: synchronous, overrides everything; same values as at power-up.
//  Simultaneous edge and n_div change: the n_div change wins. The window is discarded (no meas_valid).
// STRUCTURE
//  pll_pkg:
//   - typedef enum {IDLE, ACQ, MEAS} win_state_t.
//   - typedef enum {UNLOCKED, LOCKED} lock_state_t.
//   - localparam function cw(NW) = NW+2.
//  sub-module sync_2ff: generic 2-flop synchronizer, reset to 0. Instantiated once for refclk_in.
//  Top: counter, edge detect, window FSM, lock FSM, classifier.
// TESTING
//  1. N=32, refclk_in period=32 pclk, en=1.
//     -> meas_valid every 32 cycles with count=32; locked rises with the 4th meas_valid.
//  2. Locked at N=32, then period changes to 36.
//     -> fast=1 and count=36 on the next window; locked falls on the 2nd bad meas_valid.
//  3. Period 33 / 31 alternating, TOL=1, N=32 -> all windows good, locked stays 1.
//     Period 30 -> slow=1.
//  4. Locked, then refclk_in held low.
//     -> timeout=1 and locked=0 when cnt hits 1023 (NW=8).
//     Edges resume -> timeout=0, first window discarded, relock after 4 good windows.
//  5. Locked, n_div changed 32->40 with period 40.
//     -> locked=0 next cycle, one window discarded, relock after 4 windows of count=40.
//  6. reset pulsed mid-window while locked, and en toggled low for 1 cycle.
//     -> all outputs 0 the following cycle; no meas_valid for the first post-restart window.

Source files
------------

// File: rtl/pll_lock_detect_pkg.sv
// Shared types and helpers for the PLL lock/frequency monitor.
package pll_lock_detect_pkg;

    // Measurement window state: idle, acquiring the first refclk edge, measuring.
    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        MEAS
    } win_state_t;

    // Lock sub-state, only meaningful while measuring.
    typedef enum logic {
        UNLOCKED,
        LOCKED
    } lock_state_t;

    // Window counter width: two extra bits above n_div so a window up to ~4x N
    // is still measured exactly before saturating.
    function automatic int cw(input int nw);
        return nw + 2;
    endfunction

endpackage

// File: rtl/pll_lock_detect_if.sv
// Control and status bundle of the PLL lock monitor.
interface pll_lock_detect_if #(
    parameter int NW = 8
);
    localparam int CW = pll_lock_detect_pkg::cw(NW);

    logic          en;
    logic          refclk_in;
    logic [NW-1:0] n_div;
    logic          meas_valid;
    logic [CW-1:0] meas_count;
    logic          fast;
    logic          slow;
    logic          locked;
    logic          timeout;

    // Controller side: enables the monitor, supplies refclk and N, reads status.
    modport master (
        output en,
        output refclk_in,
        output n_div,
        input  meas_valid,
        input  meas_count,
        input  fast,
        input  slow,
        input  locked,
        input  timeout
    );

    // Monitor side.
    modport slave (
        input  en,
        input  refclk_in,
        input  n_div,
        output meas_valid,
        output meas_count,
        output fast,
        output slow,
        output locked,
        output timeout
    );

endinterface

// File: rtl/pll_lock_detect_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous single-bit signal into the
// local clock domain. Both flops clear on reset.
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    // Metastability filter: r_s1 may go metastable, r_s2 is the settled copy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock/frequency monitor. Runs on the PLL output clock, measures how many
// pclk cycles fit in each refclk period and compares that to the divider N,
// producing per-window fast/slow results and a hysteretic lock flag.
module pll_lock_detect
    import pll_lock_detect_pkg::*;
#(
    parameter int NW         = 8,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             i_pclk,
    input  logic             i_reset,
    pll_lock_detect_if.slave io_mon
);

    localparam int            CW      = cw(NW);
    localparam int            GW      = $clog2(LOCK_CNT + 1);
    localparam int            BW      = $clog2(UNLOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW:0]   TOL_X   = (CW + 1)'(TOL);

    // Window classification in CW+1 bits so N+TOL never wraps.
    // Returns {good, fast, slow}; a divider below 2 is never good.
    function automatic logic [2:0] classify(input logic [CW-1:0] count,
                                            input logic [NW-1:0] n);
        logic [CW:0] c;
        logic [CW:0] nx;
        logic [CW:0] lo;
        logic [CW:0] hi;
        logic        f;
        logic        s;
        logic        g;
        c  = (CW + 1)'(count);
        nx = (CW + 1)'(n);
        hi = nx + TOL_X;
        lo = (nx >= TOL_X) ? (nx - TOL_X) : '0;
        f  = (c > hi);
        s  = (c < lo);
        g  = !f && !s && (n >= NW'(2));
        return {g, f, s};
    endfunction

    // Synchronizer tail and edge detect
    logic w_s2;
    logic r_s3;
    logic w_edge;

    // Window counter
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    // FSMs and lock bookkeeping
    win_state_t    r_state;
    win_state_t    w_state_nxt;
    lock_state_t   r_lock;
    lock_state_t   w_lock_nxt;
    logic [GW-1:0] r_good_cnt;
    logic [GW-1:0] w_good_nxt;
    logic [BW-1:0] r_bad_cnt;
    logic [BW-1:0] w_bad_nxt;
    logic [NW-1:0] r_n_lat;

    // Per-window decisions
    logic w_ndiv_chg;
    logic w_tmo_hit;
    logic w_meas;
    logic w_good;
    logic w_fast;
    logic w_slow;

    // Registered status
    logic          r_meas_valid;
    logic [CW-1:0] r_meas_count;
    logic          r_fast;
    logic          r_slow;
    logic          r_timeout;

    sync_2ff u_sync_ref (
        .i_clk (i_pclk),
        .i_rst (i_reset),
        .i_d   (io_mon.refclk_in),
        .o_q   (w_s2)
    );

    assign w_edge = w_s2 & ~r_s3;

    assign {w_good, w_fast, w_slow} = classify(r_cnt, r_n_lat);

    // A divider change while measuring invalidates the window in flight; it
    // takes priority over a coincident refclk edge.
    assign w_ndiv_chg = (r_state == MEAS) && (io_mon.n_div != r_n_lat);
    assign w_meas     = io_mon.en && (r_state == MEAS) && w_edge && !w_ndiv_chg;

    // Fires once, on the cycle the counter is about to saturate without an edge.
    assign w_tmo_hit  = io_mon.en && (r_state != IDLE) && !w_edge &&
                        (r_cnt == CNT_MAX - 1'b1);

    // Window counter: restarts at 1 on each edge, saturates at all-ones, parked at 0 when idle.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!io_mon.en || (r_state == IDLE)) begin
            w_cnt_nxt = '0;
        end else if (w_edge) begin
            w_cnt_nxt = CW'(1);
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Window FSM next state: first edge after (re)start only aligns the counter.
    always_comb begin
        w_state_nxt = r_state;
        if (!io_mon.en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = ACQ;
                ACQ:  if (w_edge) w_state_nxt = MEAS;
                MEAS: if (w_ndiv_chg || w_tmo_hit) w_state_nxt = ACQ;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Lock FSM next state: counts consecutive good/bad windows; reset whenever measuring stops.
    always_comb begin
        w_lock_nxt = r_lock;
        w_good_nxt = r_good_cnt;
        w_bad_nxt  = r_bad_cnt;
        if ((r_state != MEAS) || (w_state_nxt != MEAS)) begin
            w_lock_nxt = UNLOCKED;
            w_good_nxt = '0;
            w_bad_nxt  = '0;
        end else if (w_meas) begin
            case (r_lock)
                UNLOCKED: begin
                    if (!w_good) begin
                        w_good_nxt = '0;
                    end else if (r_good_cnt + 1'b1 == GW'(LOCK_CNT)) begin
                        w_lock_nxt = LOCKED;
                        w_good_nxt = '0;
                        w_bad_nxt  = '0;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_good) begin
                        w_bad_nxt = '0;
                    end else if (r_bad_cnt + 1'b1 == BW'(UNLOCK_CNT)) begin
                        w_lock_nxt = UNLOCKED;
                        w_good_nxt = '0;
                        w_bad_nxt  = '0;
                    end else begin
                        w_bad_nxt = r_bad_cnt + 1'b1;
                    end
                end
                default: begin
                    w_lock_nxt = UNLOCKED;
                    w_good_nxt = '0;
                    w_bad_nxt  = '0;
                end
            endcase
        end
    end

    // State, counter and divider latch registers.
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_lock     <= UNLOCKED;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_s3       <= 1'b0;
            r_cnt      <= '0;
            r_n_lat    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lock     <= w_lock_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
            r_s3       <= w_s2;
            r_cnt      <= w_cnt_nxt;
            if ((w_state_nxt == ACQ) && (r_state != ACQ)) begin
                r_n_lat <= io_mon.n_div;
            end
        end
    end

    // Status registers: result captured with each reported window, cleared while disabled.
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            r_meas_valid <= 1'b0;
            r_meas_count <= '0;
            r_fast       <= 1'b0;
            r_slow       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= w_meas;
            if (!io_mon.en) begin
                r_meas_count <= '0;
                r_fast       <= 1'b0;
                r_slow       <= 1'b0;
                r_timeout    <= 1'b0;
            end else begin
                if (w_meas) begin
                    r_meas_count <= r_cnt;
                    r_fast       <= w_fast;
                    r_slow       <= w_slow;
                end
                if (w_edge) begin
                    r_timeout <= 1'b0;
                end else if (w_tmo_hit) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign io_mon.meas_valid = r_meas_valid;
    assign io_mon.meas_count = r_meas_count;
    assign io_mon.fast       = r_fast;
    assign io_mon.slow       = r_slow;
    assign io_mon.locked     = (r_lock == LOCKED);
    assign io_mon.timeout    = r_timeout;

endmodule

// File: tb/tb_pll_lock_detect.sv
// Directed bench for the PLL lock monitor: a refclk pattern generator plus
// hand-computed window counts, fast/slow and lock expectations.
module tb_pll_lock_detect;

    logic pclk = 1'b0;
    logic reset;

    always #5 pclk = ~pclk;

    pll_lock_detect_if #(.NW(8)) mon ();

    pll_lock_detect #(
        .NW         (8),
        .TOL        (1),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (2)
    ) dut (
        .i_pclk  (pclk),
        .i_reset (reset),
        .io_mon  (mon)
    );

    int n_tot  = 0;
    int n_bad  = 0;
    int per_a  = 0;
    int per_b  = 0;
    int pat_id = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // New refclk pattern; takes effect from the next refclk period, starting with per_a.
    task automatic set_per(input int a, input int b);
        per_a = a;
        per_b = b;
        pat_id++;
    endtask

    task automatic wait_meas(input string tag, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < 1200) begin
            tick();
            cyc++;
            if (mon.meas_valid === 1'b1) ok = 1'b1;
        end
        if (!ok) chk({tag, "_tmo"}, 32'd0, 32'd1);
    endtask

    task automatic expect_meas(input string tag, input int cnt, input int f,
                               input int s, input int l, output int cyc);
        bit ok;
        wait_meas(tag, cyc, ok);
        if (ok) begin
            chk({tag, "_cnt"},  32'(mon.meas_count), cnt);
            chk({tag, "_fast"}, 32'(mon.fast),       f);
            chk({tag, "_slow"}, 32'(mon.slow),       s);
            chk({tag, "_lock"}, 32'(mon.locked),     l);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(mon.meas_valid), 0);
        chk({tag, "_count"}, 32'(mon.meas_count), 0);
        chk({tag, "_fast"},  32'(mon.fast),       0);
        chk({tag, "_slow"},  32'(mon.slow),       0);
        chk({tag, "_lock"},  32'(mon.locked),     0);
        chk({tag, "_tmo"},   32'(mon.timeout),    0);
    endtask

    // refclk generator: high for half the period, low for the rest; 0 holds it low.
    initial begin
        int cur;
        int last_id;
        bit tgl;
        mon.refclk_in = 1'b0;
        last_id = -1;
        tgl = 1'b0;
        forever begin
            if (pat_id != last_id) begin
                last_id = pat_id;
                tgl = 1'b0;
            end
            cur = tgl ? per_b : per_a;
            tgl = ~tgl;
            if (cur < 2) begin
                mon.refclk_in = 1'b0;
                @(negedge pclk);
            end else begin
                mon.refclk_in = 1'b1;
                repeat (cur / 2) @(negedge pclk);
                mon.refclk_in = 1'b0;
                repeat (cur - cur / 2) @(negedge pclk);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen;
        reset     = 1'b1;
        mon.en    = 1'b0;
        mon.n_div = 8'd32;
        repeat (3) tick();
        chk_all_zero("rst");

        // 1: N=32, period 32; first edge discarded, lock on 4th window
        reset = 1'b0;
        mon.en = 1'b1;
        set_per(32, 32);
        for (int k = 1; k <= 4; k++) begin
            expect_meas($sformatf("t1_w%0d", k), 32, 0, 0, int'(k == 4), cyc);
            if (k > 1) chk($sformatf("t1_gap%0d", k), cyc, 32);
        end

        // 2: period 36 -> fast, unlock on 2nd bad window
        set_per(36, 36);
        expect_meas("t2_w0", 32, 0, 0, 1, cyc);
        expect_meas("t2_w1", 36, 1, 0, 1, cyc);
        expect_meas("t2_w2", 36, 1, 0, 0, cyc);

        // 3: 33/31 alternating within tolerance, then period 30 -> slow
        set_per(33, 31);
        expect_meas("t3_w0", 36, 1, 0, 0, cyc);
        for (int k = 1; k <= 6; k++) begin
            expect_meas($sformatf("t3_a%0d", k), (k % 2 == 1) ? 33 : 31, 0, 0,
                        int'(k >= 4), cyc);
        end
        set_per(30, 30);
        expect_meas("t3_s0", 33, 0, 0, 1, cyc);
        expect_meas("t3_s1", 30, 0, 1, 1, cyc);
        expect_meas("t3_s2", 30, 0, 1, 0, cyc);

        // 4: relock at 32, then refclk stops -> timeout at cnt=1023
        set_per(32, 32);
        expect_meas("t4_w0", 30, 0, 1, 0, cyc);
        for (int k = 1; k <= 4; k++) begin
            expect_meas($sformatf("t4_w%0d", k), 32, 0, 0, int'(k == 4), cyc);
        end
        set_per(0, 0);
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 1100) begin
            tick();
            cyc++;
            if (mon.timeout === 1'b1) seen = 1'b1;
        end
        chk("t4_tmo_seen", 32'(seen), 1);
        chk("t4_tmo_cyc", cyc, 1022);
        chk("t4_tmo_lock", 32'(mon.locked), 0);
        set_per(32, 32);
        expect_meas("t4_r1", 32, 0, 0, 0, cyc);
        chk("t4_discard", 32'(cyc >= 33 && cyc <= 40), 1);
        chk("t4_tmo_clr", 32'(mon.timeout), 0);
        for (int k = 2; k <= 4; k++) begin
            expect_meas($sformatf("t4_r%0d", k), 32, 0, 0, int'(k == 4), cyc);
        end

        // 5: divider 32 -> 40 with period 40
        mon.n_div = 8'd40;
        set_per(40, 40);
        tick();
        chk("t5_unlock", 32'(mon.locked), 0);
        for (int k = 1; k <= 4; k++) begin
            expect_meas($sformatf("t5_w%0d", k), 40, 0, 0, int'(k == 4), cyc);
        end

        // 6: reset pulse while refclk is low, then en low for one cycle
        repeat (25) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_all_zero("t6_rst");
        expect_meas("t6_r1", 40, 0, 0, 0, cyc);
        chk("t6_rst_discard", 32'(cyc >= 45 && cyc <= 65), 1);
        for (int k = 2; k <= 4; k++) begin
            expect_meas($sformatf("t6_r%0d", k), 40, 0, 0, int'(k == 4), cyc);
        end
        repeat (10) tick();
        mon.en = 1'b0;
        tick();
        mon.en = 1'b1;
        chk_all_zero("t6_en");
        expect_meas("t6_e1", 40, 0, 0, 0, cyc);
        chk("t6_en_discard", 32'(cyc >= 60 && cyc <= 78), 1);
        for (int k = 2; k <= 4; k++) begin
            expect_meas($sformatf("t6_e%0d", k), 40, 0, 0, int'(k == 4), cyc);
        end

        // 7: N=2 locks on period 2; N=1 reports windows but never locks
        mon.n_div = 8'd2;
        set_per(2, 2);
        tick();
        chk("t7_unlock", 32'(mon.locked), 0);
        for (int k = 1; k <= 4; k++) begin
            expect_meas($sformatf("t7_n2_%0d", k), 2, 0, 0, int'(k == 4), cyc);
        end
        mon.n_div = 8'd1;
        tick();
        chk("t7_unlock1", 32'(mon.locked), 0);
        for (int k = 1; k <= 6; k++) begin
            expect_meas($sformatf("t7_n1_%0d", k), 2, 0, 0, 0, cyc);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
